// File: rtl/f2f_pkg.sv
// Shared definitions for the float-to-fixed stream: format geometry,
// rounding mode encodings and out_flags bit positions.
package f2f_pkg;

  typedef enum logic [1:0] {
    RND_RTZ   = 2'd0,
    RND_RNA   = 2'd1,
    RND_RNE   = 2'd2,
    RND_FLOOR = 2'd3
  } rnd_mode_e;

  localparam int FLG_NAN     = 0;
  localparam int FLG_INF     = 1;
  localparam int FLG_ZERO    = 2;
  localparam int FLG_DENORM  = 3;
  localparam int FLG_OVF     = 4;
  localparam int FLG_UNF     = 5;
  localparam int FLG_INEXACT = 6;
  localparam int NUM_FLAGS   = 7;

  function automatic int float_wid(bit dbl);
    return dbl ? 64 : 32;
  endfunction

  function automatic int exp_wid(bit dbl);
    return dbl ? 11 : 8;
  endfunction

  function automatic int mant_wid(bit dbl);
    return dbl ? 52 : 23;
  endfunction

  function automatic int exp_bias(bit dbl);
    return dbl ? 1023 : 127;
  endfunction

  function automatic int sign_bit(bit dbl);
    return float_wid(dbl) - 1;
  endfunction

endpackage

// File: rtl/f2f_round_unit.sv
// Magnitude rounding from guard/sticky bits; carry-out lets the caller
// detect a round-up that crosses the saturation limit.
module f2f_round_unit
  import f2f_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] mag_i,
  input  logic         g_i,
  input  logic         s_i,
  input  logic         sign_i,
  input  rnd_mode_e    mode_i,
  output logic [W-1:0] mag_o,
  output logic         carry_o
);

  logic inc;

  always_comb begin
    unique case (mode_i)
      RND_RTZ: inc = 1'b0;
      RND_RNA: inc = g_i;
      RND_RNE: inc = g_i & (s_i | mag_i[0]);
      default: inc = sign_i & (g_i | s_i);
    endcase
  end

  assign {carry_o, mag_o} = {1'b0, mag_i} + (W+1)'(inc);

endmodule

// File: rtl/float_to_fixed_stream.sv
// Four-stage float/double to signed Q(INT_WID.FRA_WID) converter with
// valid/ready backpressure, per-sample rounding and a saturation counter.
module float_to_fixed_stream
  import f2f_pkg::*;
#(
  parameter string FLOAT_FMT = "float",
  parameter int    INT_WID   = 16,
  parameter int    FRA_WID   = 16,
  parameter bit    NAN_ZERO  = 1'b1,
  parameter int    CNT_WID   = 16,
  localparam bit   IS_DBL    = (FLOAT_FMT == "double"),
  localparam int   FLOAT_WID = float_wid(IS_DBL)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FLOAT_WID-1:0]       in_data,
  input  logic [1:0]                 in_rnd_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INT_WID+FRA_WID-1:0] out_data,
  output logic [NUM_FLAGS-1:0]       out_flags,
  input  logic                       clr_cnt,
  output logic [CNT_WID-1:0]         sat_cnt
);

  localparam int W       = INT_WID + FRA_WID;
  localparam int EW      = exp_wid(IS_DBL);
  localparam int MW      = mant_wid(IS_DBL);
  localparam int SB      = sign_bit(IS_DBL);
  localparam int L       = W + MW;
  localparam int XW      = 2 * L;
  localparam int RSW     = $clog2(L + 1);
  localparam int RS_BASE = W - 1 - FRA_WID + exp_bias(IS_DBL);
  localparam int STAGES  = 3;

  localparam logic [W:0]   POS_LIM = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0]   NEG_LIM = {2'b01, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXP    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN    = {1'b1, {(W-1){1'b0}}};

  typedef struct packed {
    logic sign;
    logic nan;
    logic inf;
    logic zero;
    logic denorm;
    logic big;
  } ctl_t;

  logic [STAGES:0]    vld_pipe_q;
  ctl_t               ctl0_q, ctl1_q, ctl2_q, ctl_d;
  rnd_mode_e          mode0_q, mode1_q;
  logic [RSW-1:0]     rs0_q, rs_d;
  logic [MW:0]        sig0_q;
  logic [2:0]         fine1_q;
  logic [XW-1:0]      x1_q, x_coarse, x_fine;
  logic [W:0]         mag2_q;
  logic               inx2_q;
  logic [W-1:0]       data_q, data_d, mag_s2, mag_r;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [CNT_WID-1:0] cnt_q, cnt_d;
  logic               adv, g_s2, s_s2, carry_s2, ovf;
  logic [EW-1:0]      e_in;
  logic [MW-1:0]      m_in;
  int                 rs_i;

  assign adv       = ~vld_pipe_q[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[STAGES];
  assign out_data  = data_q;
  assign out_flags = flags_q;
  assign sat_cnt   = cnt_q;

  // S0 decode: rs is the right shift that puts the hidden one at its
  // fixed-point weight; negative rs means the value cannot fit at all.
  assign e_in = in_data[SB-1 -: EW];
  assign m_in = in_data[MW-1:0];

  always_comb begin
    ctl_d      = '0;
    ctl_d.sign = in_data[SB];
    rs_i       = RS_BASE - int'(e_in);
    if (&e_in) begin
      ctl_d.nan = |m_in;
      ctl_d.inf = ~|m_in;
    end else if (~|e_in) begin
      ctl_d.zero   = ~|m_in;
      ctl_d.denorm = |m_in;
    end else begin
      ctl_d.big = (rs_i < 0);
    end
    rs_d = (rs_i < 0) ? '0 : (rs_i > L) ? RSW'(L) : RSW'(rs_i);
  end

  // Double-width alignment vector: shifts up to L never lose bits, so the
  // sticky bit falls out of the low half without separate accumulation.
  assign x_coarse = {sig0_q, {(XW-MW-1){1'b0}}} >> {rs0_q[RSW-1:3], 3'b000};
  assign x_fine   = x1_q >> fine1_q;
  assign mag_s2   = x_fine[XW-1 -: W];
  assign g_s2     = x_fine[XW-W-1];
  assign s_s2     = |x_fine[XW-W-2:0];

  f2f_round_unit #(.W(W)) u_round (
    .mag_i   (mag_s2),
    .g_i     (g_s2),
    .s_i     (s_s2),
    .sign_i  (ctl1_q.sign),
    .mode_i  (mode1_q),
    .mag_o   (mag_r),
    .carry_o (carry_s2)
  );

  always_comb begin
    data_d  = '0;
    flags_d = '0;
    ovf     = 1'b0;
    if (ctl2_q.nan) begin
      data_d           = NAN_ZERO ? '0 : MAXP;
      flags_d[FLG_NAN] = 1'b1;
    end else if (ctl2_q.inf) begin
      data_d           = ctl2_q.sign ? MINN : MAXP;
      flags_d[FLG_INF] = 1'b1;
      flags_d[FLG_OVF] = 1'b1;
    end else if (ctl2_q.zero) begin
      flags_d[FLG_ZERO] = 1'b1;
    end else if (ctl2_q.denorm) begin
      flags_d[FLG_DENORM] = 1'b1;
    end else begin
      ovf = ctl2_q.big | (ctl2_q.sign ? (mag2_q > NEG_LIM) : (mag2_q > POS_LIM));
      flags_d[FLG_OVF]     = ovf;
      flags_d[FLG_UNF]     = ~ovf & (mag2_q == '0);
      flags_d[FLG_INEXACT] = inx2_q & ~ctl2_q.big;
      if (ovf)              data_d = ctl2_q.sign ? MINN : MAXP;
      else if (ctl2_q.sign) data_d = W'(-mag2_q);
      else                  data_d = mag2_q[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      ctl0_q     <= '0;
      ctl1_q     <= '0;
      ctl2_q     <= '0;
      mode0_q    <= RND_RTZ;
      mode1_q    <= RND_RTZ;
      rs0_q      <= '0;
      sig0_q     <= '0;
      fine1_q    <= '0;
      x1_q       <= '0;
      mag2_q     <= '0;
      inx2_q     <= 1'b0;
      data_q     <= '0;
      flags_q    <= '0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], in_valid};
      ctl0_q     <= ctl_d;
      mode0_q    <= rnd_mode_e'(in_rnd_mode);
      rs0_q      <= rs_d;
      sig0_q     <= {1'b1, m_in};
      ctl1_q     <= ctl0_q;
      mode1_q    <= mode0_q;
      fine1_q    <= rs0_q[2:0];
      x1_q       <= x_coarse;
      ctl2_q     <= ctl1_q;
      mag2_q     <= {carry_s2, mag_r};
      inx2_q     <= g_s2 | s_s2;
      if (vld_pipe_q[STAGES-1]) begin
        data_q  <= data_d;
        flags_q <= flags_d;
      end
    end
  end

  // Clear wins over a same-cycle overflow beat; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)
      cnt_d = '0;
    else if (out_valid && out_ready && flags_q[FLG_OVF] && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_float_to_fixed_stream.sv
// Directed bench for float_to_fixed_stream (float, Q16.16, NaN -> 0).
module tb_float_to_fixed_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_rnd_mode = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [6:0]  out_flags;
  logic        clr_cnt = 1'b0;
  logic [15:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_to_fixed_stream #(
    .FLOAT_FMT ("float"),
    .INT_WID   (16),
    .FRA_WID   (16),
    .NAN_ZERO  (1'b1),
    .CNT_WID   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_rnd_mode (in_rnd_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_flags   (out_flags),
    .clr_cnt     (clr_cnt),
    .sat_cnt     (sat_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one sample with out_ready high; result must show in the 4th cycle
  // after the accept cycle. Optionally raise clr_cnt alongside the result beat.
  task automatic run_one(input string tag, input logic [31:0] d, input logic [1:0] m,
                         input logic [31:0] exp_d, input logic [6:0] exp_f,
                         input bit clr_at_out);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_rnd_mode = m;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd4);
    chk({tag, "_data"}, 64'(out_data), 64'(exp_d));
    chk({tag, "_flags"}, 64'(out_flags), 64'(exp_f));
    if (clr_at_out) clr_cnt = 1'b1;
  endtask

  logic [31:0] bp_vec [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  initial begin
    int send, rcv;
    bit prev_stall;
    logic [31:0] held;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic conversion and rounding modes
    run_one("one_p5",   32'h3FC00000, 2'd0, 32'h00018000, 7'h00, 1'b0);
    run_one("lsb_rtz",  32'h38200000, 2'd0, 32'h00000002, 7'h40, 1'b0);
    run_one("lsb_rna",  32'h38200000, 2'd1, 32'h00000003, 7'h40, 1'b0);
    run_one("lsb_rne",  32'h38200000, 2'd2, 32'h00000002, 7'h40, 1'b0);
    run_one("lsb_flr",  32'hB8200000, 2'd3, 32'hFFFFFFFD, 7'h40, 1'b0);

    // Saturation
    chk("cnt_before_sat", 64'(sat_cnt), 64'd0);
    run_one("pos_sat",  32'h471C4000, 2'd0, 32'h7FFFFFFF, 7'h10, 1'b0);
    @(negedge clk);
    chk("cnt_after_sat", 64'(sat_cnt), 64'd1);
    run_one("neg_lim",  32'hC7000000, 2'd0, 32'h80000000, 7'h00, 1'b0);
    @(negedge clk);
    chk("cnt_neg_lim", 64'(sat_cnt), 64'd1);

    // Special inputs
    run_one("nan",      32'h7FC00000, 2'd0, 32'h00000000, 7'h01, 1'b0);
    run_one("inf",      32'h7F800000, 2'd0, 32'h7FFFFFFF, 7'h12, 1'b0);
    run_one("tiny",     32'h2EDBE6FF, 2'd0, 32'h00000000, 7'h60, 1'b0);
    run_one("denorm",   32'h00000001, 2'd0, 32'h00000000, 7'h08, 1'b0);
    run_one("negzero",  32'h80000000, 2'd0, 32'h00000000, 7'h04, 1'b0);
    @(negedge clk);
    chk("cnt_after_inf", 64'(sat_cnt), 64'd2);

    // Backpressure: 8 back-to-back samples, consumer stalls cycles 6..9
    send = 0; rcv = 0; prev_stall = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 10);
      in_valid  = (send < 8);
      in_data   = bp_vec[send % 8];
      in_rnd_mode = 2'd0;
      #1;
      if (prev_stall) chk("bp_hold", 64'(out_data), 64'(held));
      chk("bp_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        chk("bp_data", 64'(out_data), 64'(32'(rcv + 1) << 16));
        rcv++;
      end
      prev_stall = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) send++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", 64'(rcv), 64'd8);

    // Reset mid-stream while a result is on the output
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = bp_vec[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_cnt", 64'(sat_cnt), 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(sat_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_one("post_rst", 32'h40400000, 2'd0, 32'h00030000, 7'h00, 1'b0);

    // clr_cnt coincident with an overflow beat
    run_one("sat_a", 32'h471C4000, 2'd0, 32'h7FFFFFFF, 7'h10, 1'b0);
    @(negedge clk);
    chk("cnt_sat_a", 64'(sat_cnt), 64'd1);
    run_one("sat_clr", 32'h7F800000, 2'd0, 32'h7FFFFFFF, 7'h12, 1'b1);
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("cnt_clr_wins", 64'(sat_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
